// File: rtl/simon_btn_rx.sv
// simon_btn_rx
//   Button front end for the Simon Says game. Synchronizes the four raw
//   push-buttons and debounces them against a millisecond time base. Chords
//   of two or more buttons are rejected. Each physical press becomes one
//   event on a valid/ready handshake to the game FSM. A one-hot "held"
//   vector is provided for LED echo.
//
//   Optional feature: define SIMON_BTN_RELEASE_EVT_EN to add the evt_release
//   port. Releases then also generate events (evt_release=1). Without the
//   macro, only press events exist and the port is absent.
//
// Ports
//   clk              system clock
//   rst              asynchronous, active-low reset
//   ticks_per_milli  clk cycles per millisecond (0 behaves as 1)
//   enable           1 = accept presses, 0 = flush and ignore
//   btn              raw active-high buttons, asynchronous to clk
//   evt_valid        event pending
//   evt_ready        consumer accepts the pending event
//   evt_idx          button index of the pending event
//   evt_release      pending event is a release (macro builds only)
//   evt_overflow     one-cycle pulse when an event is dropped
//   held             one-hot of the accepted button while it is held
module simon_btn_rx #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        enable,
    input  logic [3:0]  btn,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_idx,
`ifdef SIMON_BTN_RELEASE_EVT_EN
    output logic        evt_release,
`endif
    output logic        evt_overflow,
    output logic [3:0]  held
);

    localparam int              MS_W    = $clog2(DEBOUNCE_MS + 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(DEBOUNCE_MS - 1);

    typedef enum logic [1:0] {
        IDLE,
        QUAL_PRESS,
        HELD,
        QUAL_REL
    } state_t;

    state_t          state, state_next;
    logic [1:0]      cap, cap_next;
    logic [3:0]      sync_meta, s;
    logic [15:0]     presc, presc_last;
    logic [MS_W-1:0] ms_cnt;
    logic            ms_tick, ms_done;
    logic            s_onehot;
    logic [1:0]      s_idx;
    logic [3:0]      cap_onehot;
    logic            new_evt;
`ifdef SIMON_BTN_RELEASE_EVT_EN
    logic            new_rel;
`endif

    // Two-flop synchronizer; everything downstream uses s only.
    // NOTE: sequential state is always written with non-blocking (<=) so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= '0;
            s         <= '0;
        end else begin
            sync_meta <= btn;
            s         <= sync_meta;
        end
    end

    // A zero prescale setting behaves like one clock per millisecond.
    assign presc_last = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    // >= rather than == so a shrinking ticks_per_milli still wraps promptly.
    assign ms_tick    = (presc >= presc_last);
    assign ms_done    = ms_tick && (ms_cnt == MS_LAST);

    assign s_onehot   = (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    assign cap_onehot = 4'b0001 << cap;

    always_comb begin
        s_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) s_idx = 2'(i);
        end
    end

    // The time base only runs while qualifying. Any state change restarts
    // it, which covers entry into both QUAL states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (state_next != state) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (state == QUAL_PRESS || state == QUAL_REL) begin
            if (ms_tick) begin
                presc  <= '0;
                ms_cnt <= ms_cnt + 1'b1;
            end else begin
                presc  <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cap   <= 2'd0;
        end else begin
            state <= state_next;
            cap   <= cap_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cap_next   = cap;
        new_evt    = 1'b0;
`ifdef SIMON_BTN_RELEASE_EVT_EN
        new_rel    = 1'b0;
`endif
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (s_onehot) begin
                        state_next = QUAL_PRESS;
                        cap_next   = s_idx;
                    end
                end
                QUAL_PRESS: begin
                    if (s != cap_onehot) begin
                        state_next = IDLE;
                    end else if (ms_done) begin
                        state_next = HELD;
                        new_evt    = 1'b1;
                    end
                end
                HELD: begin
                    // Extra buttons while held are ignored; only full release counts.
                    if (s == 4'd0) state_next = QUAL_REL;
                end
                QUAL_REL: begin
                    if (s != 4'd0) begin
                        state_next = HELD;
                    end else if (ms_done) begin
                        state_next = IDLE;
`ifdef SIMON_BTN_RELEASE_EVT_EN
                        new_evt    = 1'b1;
                        new_rel    = 1'b1;
`endif
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign held = (state == HELD || state == QUAL_REL) ? cap_onehot : 4'd0;

    // One-deep event register. A new event arriving while the old one is
    // stalled is dropped and flagged; the pending event is never disturbed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_valid    <= 1'b0;
            evt_idx      <= 2'd0;
            evt_overflow <= 1'b0;
`ifdef SIMON_BTN_RELEASE_EVT_EN
            evt_release  <= 1'b0;
`endif
        end else begin
            evt_overflow <= 1'b0;
            if (!enable) begin
                evt_valid <= 1'b0;
            end else if (new_evt) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid   <= 1'b1;
                    evt_idx     <= cap;
`ifdef SIMON_BTN_RELEASE_EVT_EN
                    evt_release <= new_rel;
`endif
                end else begin
                    evt_overflow <= 1'b1;
                end
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simon_btn_rx.sv
// tb_simon_btn_rx
//   Directed bench for simon_btn_rx with DEBOUNCE_MS=3 and ticks_per_milli=2,
//   which gives a 6-cycle qualification window. A behavioural model counts
//   stable cycles directly. One negedge process compares the DUT against
//   that model on every cycle. Literal expectations pin the key timings.
module tb_simon_btn_rx;

    localparam int DMS = 3;
    localparam int TPM = 2;
    localparam int WIN = DMS * TPM;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ticks_per_milli = 16'(TPM);
    logic        enable = 1'b1;
    logic [3:0]  btn = 4'd0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [1:0]  evt_idx;
    logic        evt_overflow;
    logic [3:0]  held;
`ifdef SIMON_BTN_RELEASE_EVT_EN
    logic        evt_release;
`endif

    int checks   = 0;
    int failures = 0;

    simon_btn_rx #(.DEBOUNCE_MS(DMS)) dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .enable          (enable),
        .btn             (btn),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_idx         (evt_idx),
`ifdef SIMON_BTN_RELEASE_EVT_EN
        .evt_release     (evt_release),
`endif
        .evt_overflow    (evt_overflow),
        .held            (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_down: a button has been accepted as pressed.
    // m_run : cycles the target level has been seen stable (-1 = not timing).
    logic [3:0] m_s1 = '0, m_s2 = '0;
    logic       m_down = 1'b0;
    int         m_run = -1;
    logic [1:0] m_cap = '0;
    logic       m_valid = 1'b0, m_ovf = 1'b0, m_rel = 1'b0;
    logic [1:0] m_idx = '0;
    logic       m_ev, m_ev_rel;
    logic [3:0] m_target;

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_down = 1'b0; m_run = -1; m_cap = '0;
            m_valid = 1'b0; m_ovf = 1'b0; m_rel = 1'b0; m_idx = '0;
        end else begin
            m_ev = 1'b0;
            m_ev_rel = 1'b0;
            if (!enable) begin
                m_down = 1'b0;
                m_run  = -1;
            end else if (m_run < 0) begin
                if (!m_down && $countones(m_s2) == 1) begin
                    m_cap = low_idx(m_s2);
                    m_run = 0;
                end else if (m_down && m_s2 == 4'd0) begin
                    m_run = 0;
                end
            end else begin
                m_target = m_down ? 4'd0 : (4'b0001 << m_cap);
                if (m_s2 != m_target) begin
                    m_run = -1;
                end else begin
                    m_run++;
                    if (m_run == WIN) begin
                        m_run = -1;
                        if (!m_down) begin
                            m_down = 1'b1;
                            m_ev   = 1'b1;
                        end else begin
                            m_down = 1'b0;
`ifdef SIMON_BTN_RELEASE_EVT_EN
                            m_ev     = 1'b1;
                            m_ev_rel = 1'b1;
`endif
                        end
                    end
                end
            end
            m_ovf = 1'b0;
            if (!enable) begin
                m_valid = 1'b0;
            end else if (m_ev) begin
                if (!m_valid || evt_ready) begin
                    m_valid = 1'b1;
                    m_idx   = m_cap;
                    m_rel   = m_ev_rel;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (evt_ready) begin
                m_valid = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("cmp_valid", 32'(evt_valid), 32'(m_valid));
            check("cmp_ovf", 32'(evt_overflow), 32'(m_ovf));
            check("cmp_held", 32'(held), 32'(m_down ? (4'b0001 << m_cap) : 4'd0));
            if (m_valid) check("cmp_idx", 32'(evt_idx), 32'(m_idx));
`ifdef SIMON_BTN_RELEASE_EVT_EN
            if (m_valid) check("cmp_rel", 32'(evt_release), 32'(m_rel));
`endif
        end
    end

    // Called from a negedge right after driving inputs: the drive is
    // sampled at the next posedge E, and wait_edges(k) then observes the
    // outputs produced by edge E+k-1.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        int ovf_cnt;
        int bad;
        int lat;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_idx", 32'(evt_idx), 0);
        check("rst_ovf", 32'(evt_overflow), 0);
        check("rst_held", 32'(held), 0);
        rst = 1'b1;
        wait_edges(3);

        // Clean press of btn2: single-cycle event at E+8, held from E+8.
        btn = 4'b0100;
        wait_edges(8);
        check("press_early", 32'(evt_valid), 0);
        wait_edges(1);
        check("press_valid", 32'(evt_valid), 1);
        check("press_idx", 32'(evt_idx), 2);
        check("press_held", 32'(held), 32'h4);
        wait_edges(1);
        check("press_1cyc", 32'(evt_valid), 0);
        check("press_held2", 32'(held), 32'h4);
        // Release: held drops at F+8 after the raw fall.
        btn = 4'b0000;
        wait_edges(8);
        check("rel_held_late", 32'(held), 32'h4);
        wait_edges(1);
        check("rel_held_drop", 32'(held), 0);
        wait_edges(4);

        // Short glitch and a chord: nothing may come out.
        btn = 4'b0001;
        wait_edges(3);
        btn = 4'b0000;
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            wait_edges(1);
            if (evt_valid || held != 4'd0) hits++;
        end
        check("glitch_quiet", 32'(hits), 0);
        btn = 4'b0011;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            if (evt_valid || held != 4'd0) hits++;
        end
        check("chord_quiet", 32'(hits), 0);
        btn = 4'b0000;
        wait_edges(4);

        // Overflow: btn0 event stalls, a later btn3 press is dropped.
        evt_ready = 1'b0;
        btn = 4'b0001;
        wait_edges(9);
        check("ovf_first_valid", 32'(evt_valid), 1);
        check("ovf_first_idx", 32'(evt_idx), 0);
        btn = 4'b0000;
        wait_edges(12);
        btn = 4'b1000;
        ovf_cnt = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            wait_edges(1);
            if (evt_overflow) ovf_cnt++;
            if (!evt_valid || evt_idx != 2'd0) bad++;
        end
        check("ovf_pulses", 32'(ovf_cnt), 1);
        check("ovf_kept", 32'(bad), 0);

        // Enable low flushes the pending event and blocks new presses.
        enable = 1'b0;
        wait_edges(1);
        check("en_flush_valid", 32'(evt_valid), 0);
        check("en_flush_held", 32'(held), 0);
        btn = 4'b0000;
        wait_edges(3);
        btn = 4'b0100;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            wait_edges(1);
            if (evt_valid || held != 4'd0) hits++;
        end
        check("en_off_quiet", 32'(hits), 0);
        btn = 4'b0000;
        wait_edges(3);
        enable = 1'b1;
        evt_ready = 1'b1;
        wait_edges(3);

        // Async reset mid-qualification, then a full window after release.
        btn = 4'b0100;
        wait_edges(5);
        #2 rst = 1'b0;
        #1;
        check("arst_q_valid", 32'(evt_valid), 0);
        check("arst_q_held", 32'(held), 0);
        @(negedge clk);
        rst = 1'b1;
        lat = 0;
        while (!evt_valid && lat < 30) begin
            wait_edges(1);
            lat++;
        end
        // E'+8 is observed on the 9th sample.
        check("arst_latency", 32'(lat), 9);
        wait_edges(2);
        check("arst_h_pre", 32'(held), 32'h4);
        #2 rst = 1'b0;
        #1;
        check("arst_h_held", 32'(held), 0);
        check("arst_h_valid", 32'(evt_valid), 0);
        btn = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        wait_edges(4);

        // Press and release of btn1: release event only with the macro.
        btn = 4'b0010;
        wait_edges(9);
        check("b1_press_valid", 32'(evt_valid), 1);
        check("b1_press_idx", 32'(evt_idx), 1);
`ifdef SIMON_BTN_RELEASE_EVT_EN
        check("b1_press_rel", 32'(evt_release), 0);
`endif
        wait_edges(1);
        btn = 4'b0000;
        wait_edges(9);
        check("b1_rel_held", 32'(held), 0);
`ifdef SIMON_BTN_RELEASE_EVT_EN
        check("b1_rel_valid", 32'(evt_valid), 1);
        check("b1_rel_idx", 32'(evt_idx), 1);
        check("b1_rel_flag", 32'(evt_release), 1);
`else
        check("b1_rel_silent", 32'(evt_valid), 0);
`endif
        wait_edges(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_btn_rx.md
# simon_btn_rx

Button front end for the Simon Says game: synchronizes the four raw push-buttons, debounces them against a millisecond time base, rejects multi-button chords, and delivers one clean press event per physical press to the game FSM over a valid/ready handshake. It sits between the board pins (BTN0..BTN3) and the game FSM, on the input side, and is the counterpart of the LED/sound output path. It also exports a one-hot "held" vector for LED echo.

## Interface
- DEBOUNCE_MS, 20: milliseconds a level must be stable before it is accepted.
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- ticks_per_milli  input  16  clk cycles per millisecond; 0 is treated as 1
- enable  input  1  1 = accept presses; 0 = flush and ignore, e.g. during sequence playback
- btn  input  4  raw buttons, active-high, asynchronous to clk
- evt_valid  output  1  press event pending
- evt_ready  input  1  consumer accepts the event
- evt_idx  output  2  button index of the pending event
- evt_release  output  1  event is a release; present only with SIMON_BTN_RELEASE_EVT_EN
- evt_overflow  output  1  one-cycle pulse when an event is dropped
- held  output  4  one-hot of the accepted button while it is held, otherwise 0

## Operation
- Synchronizer: 2 flops per bit, reset to 0. All logic uses the synchronized value `s`.
- Prescaler: counts 0..max(ticks_per_milli,1)-1 and wraps. `ms_tick` is high while the count is at the maximum. The prescaler and the ms counter are cleared on entry to either QUAL state.
- FSM states: IDLE, QUAL_PRESS, HELD, QUAL_REL. Reset state is IDLE.
  - IDLE: if enable and `s` is exactly one-hot, capture the index into `cap` and go to QUAL_PRESS. Zero bits or two or more bits: stay.
  - QUAL_PRESS: if `s` != onehot(cap), go to IDLE. Otherwise, on ms_tick with ms_cnt == DEBOUNCE_MS-1, raise the press event and go to HELD. Otherwise increment ms_cnt on ms_tick.
  - HELD: when `s` == 0, go to QUAL_REL. Other bits pressed while held are ignored.
  - QUAL_REL: if `s` != 0, go to HELD. On ms_tick with ms_cnt == DEBOUNCE_MS-1, go to IDLE and raise a release event if the macro is defined.
- held = onehot(cap) in HELD and QUAL_REL, otherwise 0.
- enable low: next edge forces IDLE and clears evt_valid. No events are raised while enable is low.
- Event register is one deep and holds idx and release.
  - New event with evt_valid == 0, or with evt_valid && evt_ready on the same edge: the register loads and evt_valid = 1.
  - New event with evt_valid && !evt_ready: the new event is dropped, the old one is kept, and evt_overflow pulses for 1 cycle.
  - evt_valid && evt_ready with no new event: evt_valid = 0.
- ms_cnt width: clog2(DEBOUNCE_MS+1). DEBOUNCE_MS >= 1.

## Timing
- Reset values: evt_valid=0, evt_idx=0, evt_release=0, evt_overflow=0, held=0. State = IDLE, all counters 0.
- Reset is asynchronous; asserting it mid-qualification or with an event pending discards everything.
- Press latency: if a raw bit goes high and stays high from edge E, then:
  - `s` is high after E+1.
  - QUAL_PRESS is entered at E+2.
  - evt_valid rises at E+2+DEBOUNCE_MS*ticks_per_milli.
  - held rises at the same edge.
- Release latency: the same formula, measured from the raw fall. held drops when IDLE is entered.
- A glitch shorter than the qualification window produces no event and no held.
- evt_idx and evt_release are stable whenever evt_valid is high.

## Configuration
- SIMON_BTN_RELEASE_EVT_EN defined:
  - The QUAL_REL→IDLE transition raises an event with evt_release=1 and evt_idx=cap.
  - Press events carry evt_release=0.
- Undefined:
  - The evt_release port is absent.
  - Only press events are generated.
  - QUAL_REL→IDLE is silent.

## Test plan
All scenarios use ticks_per_milli=2 and DEBOUNCE_MS=3, so the qualification window is 6 cycles.
- Clean press on btn=0100 from edge E, evt_ready=1 -> evt_valid high for exactly 1 cycle at E+8 with evt_idx=2; held=0100 from E+8.
- 3-cycle pulse on btn=0001 -> no evt_valid and held stays 0. Chord btn=0011 held for 20 cycles -> no event.
- Press btn0 and hold evt_ready=0; release and press btn3 -> evt_valid stays high with idx=0, evt_overflow pulses once at the second event, no other change.
- Press with evt_ready=0, then drop enable -> evt_valid=0 at the next edge; presses while enable=0 yield nothing.
- Async rst low during QUAL_PRESS and during HELD -> all outputs 0 immediately; after rst release with the button still held, a full window elapses before the event.
- With SIMON_BTN_RELEASE_EVT_EN: press then release btn1 -> press event (idx=1, release=0), then a release event (idx=1, release=1) 8 edges after the raw fall.
